sprite_line_scan: RTL

Per-scanline sprite attribute scanner that sequences the read port of the 256×32 sprite attribute RAM.
- On each line start it walks all 128 sprite entries (two 32-bit words each) and selects the enabled sprites that intersect the current line.
- Selected sprites are delivered one at a time over a valid/ready hit port to the sprite line renderer.
- Sits between the video timing generator and the sprite attribute RAM read port; the CPU-side write port of that RAM is not touched.

---
 rtl/sprite_line_scan.sv | 110 +++++++++++
 1 files changed

// File: rtl/sprite_line_scan.sv
// sprite_line_scan: per-line scan of the 128-entry sprite attribute RAM, streaming the sprites that hit over valid/ready.
module sprite_line_scan #(
  parameter int MAX_HITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  input  logic        enable_i,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        hit_valid_o,
  input  logic        hit_ready_i,
  output logic [6:0]  hit_id_o,
  output logic [31:0] hit_word0_o,
  output logic [31:0] hit_word1_o,
  output logic [5:0]  hit_row_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [7:0]  hit_cnt_o
);
  typedef enum logic [2:0] {IDLE, F0, F1, F2, CHECK} state_t;
  state_t state, state_nx;
  logic [6:0]  idx, idx_nx, height;
  logic [9:0]  line, diff;
  logic [31:0] word0, word1;
  logic        hit, full, free, abort, load, adv, done_nx, ovf_set;
  assign busy_o = state != IDLE;
  always_comb begin
    diff = line - word1[9:0];
    height = 7'd8 << word1[31:30];
    hit = (word1[19:18] != 2'd0) && (diff < {3'd0, height});
    full = hit_cnt_o == 8'(MAX_HITS);
    free = !hit_valid_o || hit_ready_i;
    abort = line_start_i && state != IDLE;
    state_nx = state;
    load = 1'b0;
    adv = 1'b0;
    done_nx = 1'b0;
    ovf_set = 1'b0;
    case (state)
      IDLE: begin
        state_nx = line_start_i && enable_i ? F0 : IDLE;
        done_nx = line_start_i && !enable_i;
      end
      F0: state_nx = F1;
      F1: state_nx = F2;
      F2: state_nx = CHECK;
      CHECK: begin
        if (hit && full) begin
          ovf_set = 1'b1;
          done_nx = 1'b1;
          state_nx = IDLE;
        end else if (!hit || free) begin
          load = hit;
          adv = 1'b1;
          done_nx = idx == 7'd127;
          state_nx = idx == 7'd127 ? IDLE : F0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // a line start mid-scan discards everything and restarts from sprite 0
    if (abort) begin
      state_nx = F0;
      load = 1'b0;
      adv = 1'b0;
      done_nx = 1'b0;
      ovf_set = 1'b0;
    end
    idx_nx = line_start_i && state_nx == F0 ? 7'd0 : idx + {6'd0, adv};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      line <= '0;
      word0 <= '0;
      word1 <= '0;
      rd_addr_o <= '0;
      hit_valid_o <= 1'b0;
      hit_id_o <= '0;
      hit_word0_o <= '0;
      hit_word1_o <= '0;
      hit_row_o <= '0;
      done_o <= 1'b0;
      overflow_o <= 1'b0;
      hit_cnt_o <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      done_o <= done_nx;
      if (state_nx == F0) rd_addr_o <= {idx_nx, 1'b0};
      else if (state_nx == F1) rd_addr_o <= {idx, 1'b1};
      if (state == F1) word0 <= rd_data_i;
      if (state == F2) word1 <= rd_data_i;
      if (line_start_i) line <= line_i;
      hit_cnt_o <= line_start_i ? 8'd0 : hit_cnt_o + {7'd0, load};
      overflow_o <= !line_start_i && (overflow_o || ovf_set);
      hit_valid_o <= !abort && (load || (hit_valid_o && !hit_ready_i));
      if (load) begin
        hit_id_o <= idx;
        hit_word0_o <= word0;
        hit_word1_o <= word1;
        hit_row_o <= diff[5:0];
      end
    end
  end
endmodule
